// File: rtl/ad9866_spi_responder.sv
// rtl/ad9866_spi_responder.sv - AD9866 serial control port slave with shadow register file
// Decodes 16-bit R/W frames from a synchronized sen_n/sclk/sdio link and answers reads on spi_sdo.
module ad9866_spi_responder #(
  parameter int NUM_REGS    = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sen_n,
  input  logic        spi_sclk,
  input  logic        spi_sdio,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  output logic        reg_wr_stb,
  output logic [4:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic [7:0]  rx_gain_reg,
  output logic [7:0]  tx_gain_reg,
  output logic        frame_err,
  output logic [15:0] frame_count
);
  typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;
  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sclk_sync, sen_sync, sdio_sync;
  logic sclk_d, sen_d, post_rst, armed;
  logic sclk_s, sen_s, sdio_s;
  logic rise_v, fall_v, sen_fall, sen_rise;

  state_t state, state_nx;
  logic start, shift_in, count_rise, instr_done, wr_done, rd_done;
  logic rd_load, rd_shift, err, oe_off, last_bit, n_bad;
  logic [7:0] shreg, in_byte, rd_shreg, rd_val, pend_data;
  logic [2:0] bit_cnt;
  logic [4:0] addr_q;
  logic wr_pend;
  logic [7:0] regs [NUM_REGS];

  // After reset, a frame is only accepted once sen_n has been seen high on the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      sen_sync  <= '1;
      sdio_sync <= '0;
      sclk_d    <= 1'b0;
      sen_d     <= 1'b1;
      post_rst  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      sen_sync  <= {sen_sync[SYNC_STAGES-2:0], spi_sen_n};
      sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], spi_sdio};
      sclk_d    <= sclk_s;
      sen_d     <= sen_s;
      post_rst  <= 1'b1;
      armed     <= armed | (post_rst & (&sen_sync) & sen_d);
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign sen_s    = sen_sync[SYNC_STAGES-1];
  assign sdio_s   = sdio_sync[SYNC_STAGES-1];
  assign sen_fall = ~sen_s & sen_d;
  assign sen_rise = sen_s & ~sen_d;
  // Edges still count in the cycle sen_n rises, so a final edge beats the deassertion.
  assign rise_v   = sclk_s & ~sclk_d & ~(sen_s & sen_d);
  assign fall_v   = ~sclk_s & sclk_d & ~(sen_s & sen_d);
  assign in_byte  = {shreg[6:0], sdio_s};
  assign last_bit = (bit_cnt == 3'd7);
  assign n_bad    = |in_byte[6:5];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = INSTR;
      INSTR: begin
        if (sen_rise) state_nx = IDLE;
        else if (instr_done) state_nx = n_bad ? DONE : (in_byte[7] ? RDATA : WDATA);
      end
      WDATA, RDATA: begin
        if (sen_rise) state_nx = IDLE;
        else if (wr_done || rd_done) state_nx = DONE;
      end
      DONE:  if (sen_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    shift_in   = 1'b0;
    count_rise = 1'b0;
    instr_done = 1'b0;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    rd_load    = 1'b0;
    rd_shift   = 1'b0;
    err        = 1'b0;
    oe_off     = sen_rise;
    case (state)
      IDLE:  start = sen_fall & armed;
      INSTR: begin
        shift_in   = rise_v;
        count_rise = rise_v;
        instr_done = rise_v & last_bit;
        rd_load    = instr_done & in_byte[7] & ~n_bad & ~sen_rise;
        err        = sen_rise | (instr_done & n_bad);
      end
      WDATA: begin
        shift_in   = rise_v;
        count_rise = rise_v;
        wr_done    = rise_v & last_bit;
        err        = sen_rise & ~wr_done;
      end
      RDATA: begin
        count_rise = rise_v;
        rd_done    = rise_v & last_bit;
        // The fall right after the instruction byte keeps data[7] on the line for the first capture.
        rd_shift   = fall_v & (bit_cnt != 3'd0);
        err        = sen_rise & ~rd_done;
      end
      DONE:  oe_off = sen_rise | fall_v;
      default: ;
    endcase
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (in_byte[4:0] == 5'(i)) rd_val = regs[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      addr_q      <= '0;
      wr_pend     <= 1'b0;
      pend_data   <= '0;
      rd_shreg    <= '0;
      spi_sdo_oe  <= 1'b0;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      reg_wr_stb <= 1'b0;
      frame_err  <= err;
      wr_pend    <= wr_done;
      if (start || instr_done) bit_cnt <= '0;
      else if (count_rise)     bit_cnt <= bit_cnt + 3'd1;
      if (shift_in)   shreg     <= in_byte;
      if (instr_done) addr_q    <= in_byte[4:0];
      if (wr_done)    pend_data <= in_byte;
      if (wr_pend || rd_done) frame_count <= frame_count + 16'd1;
      if (wr_pend && ({1'b0, addr_q} < REG_LIMIT)) begin
        reg_wr_stb  <= 1'b1;
        reg_wr_addr <= addr_q;
        reg_wr_data <= pend_data;
        for (int i = 0; i < NUM_REGS; i++)
          if (addr_q == 5'(i)) regs[i] <= pend_data;
      end
      if (rd_load) begin
        rd_shreg   <= rd_val;
        spi_sdo_oe <= 1'b1;
      end else begin
        if (oe_off)   spi_sdo_oe <= 1'b0;
        if (rd_shift) rd_shreg   <= {rd_shreg[6:0], 1'b0};
      end
    end
  end

  assign spi_sdo = spi_sdo_oe & rd_shreg[7];

  if (NUM_REGS > 9) begin : g_rx
    assign rx_gain_reg = regs[9];
  end else begin : g_rx_none
    assign rx_gain_reg = '0;
  end

  if (NUM_REGS > 10) begin : g_tx
    assign tx_gain_reg = regs[10];
  end else begin : g_tx_none
    assign tx_gain_reg = '0;
  end
endmodule

// File: tb/tb_ad9866_spi_responder.sv
// tb/tb_ad9866_spi_responder.sv - directed bench for the AD9866 serial port responder
// A bit-banged master (sclk = clk/8) drives frames; a register model predicts read-back and counts.
`timescale 1ns/1ps
module tb_ad9866_spi_responder;
  localparam int NREGS = 20;

  logic clk = 1'b0, rst = 1'b1;
  logic spi_sen_n = 1'b1, spi_sclk = 1'b0, spi_sdio = 1'b0;
  logic spi_sdo, spi_sdo_oe, reg_wr_stb, frame_err;
  logic [4:0] reg_wr_addr;
  logic [7:0] reg_wr_data, rx_gain_reg, tx_gain_reg;
  logic [15:0] frame_count;

  ad9866_spi_responder #(.NUM_REGS(NREGS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_sen_n(spi_sen_n), .spi_sclk(spi_sclk), .spi_sdio(spi_sdio),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .reg_wr_stb(reg_wr_stb),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .rx_gain_reg(rx_gain_reg),
    .tx_gain_reg(tx_gain_reg), .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int stb_cnt = 0, err_cnt = 0, exp_fc = 0;
  time stb_t = 0, rise_t = 0;
  logic [7:0] exp_regs [32];

  always @(negedge clk) begin
    if (reg_wr_stb) begin stb_cnt++; stb_t = $time; end
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] w, input int nbits, input bit sen_lo, input bit sen_hi,
                      output logic [7:0] rd, output int oe_hits);
    rd = '0;
    oe_hits = 0;
    @(negedge clk);
    if (sen_lo) spi_sen_n = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      spi_sdio = w[15-i];
      #40;
      if (i >= 8) begin
        rd = {rd[6:0], spi_sdo};
        if (spi_sdo_oe) oe_hits++;
      end
      spi_sclk = 1'b1;
      rise_t = $time;
      #40;
      spi_sclk = 1'b0;
    end
    #40;
    if (sen_hi) spi_sen_n = 1'b1;
    #80;
  endtask

  task automatic wr(input logic [15:0] w);
    logic [7:0] rd;
    int hits;
    xfer(w, 16, 1'b1, 1'b1, rd, hits);
    exp_fc++;
    if (w[12:8] < 5'(NREGS)) exp_regs[w[12:8]] = w[7:0];
  endtask

  task automatic rd_chk(input logic [4:0] a);
    logic [7:0] rd;
    int hits;
    xfer({3'b100, a, 8'h00}, 16, 1'b1, 1'b1, rd, hits);
    exp_fc++;
    check($sformatf("read 0x%02h data", a), rd, exp_regs[a]);
    check($sformatf("read 0x%02h oe bits", a), hits, 8);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int hits, s0, e0;
    for (int i = 0; i < 32; i++) exp_regs[i] = 8'h00;

    repeat (4) @(negedge clk);
    check("reset stb", reg_wr_stb, 0);
    check("reset sdo_oe", spi_sdo_oe, 0);
    check("reset sdo", spi_sdo, 0);
    check("reset frame_err", frame_err, 0);
    check("reset frame_count", frame_count, 0);
    check("reset rx_gain", rx_gain_reg, 0);
    check("reset tx_gain", tx_gain_reg, 0);
    check("reset wr_addr/data", {reg_wr_addr, reg_wr_data}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    s0 = stb_cnt;
    wr(16'h0A45);
    check("w0A45 stb count", stb_cnt - s0, 1);
    check("w0A45 wr_addr", reg_wr_addr, 5'h0A);
    check("w0A45 wr_data", reg_wr_data, 8'h45);
    check("w0A45 tx_gain", tx_gain_reg, 8'h45);
    check("w0A45 frame_count", frame_count, 1);
    check("write latency cycles", 32'((stb_t - rise_t) / 10), 4);

    wr(16'h0955);
    s0 = stb_cnt;
    xfer(16'h8900, 16, 1'b1, 1'b1, rd, hits);
    exp_fc++;
    check("r09 data", rd, 8'h55);
    check("r09 oe bits", hits, 8);
    check("r09 no strobe", stb_cnt - s0, 0);
    check("r09 frame_count", frame_count, 3);
    check("r09 oe released", spi_sdo_oe, 0);
    check("rx_gain after w0955", rx_gain_reg, 8'h55);

    wr(16'h0436);
    wr(16'h0614);
    wr(16'h0721);
    wr(16'h1200);
    for (int a = 0; a < NREGS; a++) rd_chk(5'(a));
    check("init list frame_count", frame_count, exp_fc);

    e0 = err_cnt;
    s0 = stb_cnt;
    xfer(16'h2A11, 16, 1'b1, 1'b1, rd, hits);
    check("bad N err pulse", err_cnt - e0, 1);
    check("bad N no strobe", stb_cnt - s0, 0);
    check("bad N frame_count", frame_count, exp_fc);
    check("bad N tx_gain kept", tx_gain_reg, 8'h45);
    wr(16'h0B07);
    rd_chk(5'h0B);

    e0 = err_cnt;
    xfer(16'h0A7F, 11, 1'b1, 1'b1, rd, hits);
    check("short frame err pulse", err_cnt - e0, 1);
    check("short frame tx_gain kept", tx_gain_reg, 8'h45);
    check("short frame frame_count", frame_count, exp_fc);
    s0 = stb_cnt;
    wr(16'h1512);
    check("w15 no strobe", stb_cnt - s0, 0);
    check("w15 frame_count", frame_count, exp_fc);
    rd_chk(5'h15);

    e0 = err_cnt;
    s0 = stb_cnt;
    xfer(16'h09FF, 12, 1'b1, 1'b0, rd, hits);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) exp_regs[i] = 8'h00;
    exp_fc = 0;
    check("rst mid-frame rx_gain", rx_gain_reg, 0);
    check("rst mid-frame tx_gain", tx_gain_reg, 0);
    check("rst mid-frame frame_count", frame_count, 0);
    check("rst mid-frame no strobe", stb_cnt - s0, 0);
    xfer(16'h0933, 16, 1'b0, 1'b1, rd, hits);
    check("unarmed frame no strobe", stb_cnt - s0, 0);
    check("unarmed frame rx_gain", rx_gain_reg, 0);
    check("unarmed frame frame_count", frame_count, 0);
    check("unarmed frame no err", err_cnt - e0, 0);
    wr(16'h0977);
    check("rearmed rx_gain", rx_gain_reg, 8'h77);
    check("rearmed frame_count", frame_count, exp_fc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
